// File: rtl/pwm_cfg_pkg.sv
// Shared types for the PWM configuration scheduler: channel FSM states,
// the write payload struct and the sanitising rules applied at acceptance.
package pwm_cfg_pkg;

  localparam int DEF_CNT_WIDTH = 8;
  // Payload fields are sized for the widest supported counter; narrower
  // instances zero-extend into them and truncate back out.
  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] duty;
    logic [CFG_W-1:0] offset;
    logic             en;
  } pwm_cfg_t;

  function automatic pwm_cfg_t cfg_sanitize(input pwm_cfg_t c);
    pwm_cfg_t s;
    s = c;
    if (c.duty > c.period)   s.duty   = c.period;
    if (c.offset > c.period) s.offset = '0;
    if (c.period == '0)      s.en     = 1'b0;
    return s;
  endfunction

  // True only when sanitising actually alters the payload.
  function automatic logic cfg_bad(input pwm_cfg_t c);
    return (c.duty > c.period) || (c.offset > c.period) ||
           ((c.period == '0) && c.en);
  endfunction

endpackage

// File: rtl/pwm_cfg_chan.sv
// One PWM channel's shadow register, active register and IDLE/RUN/PEND FSM.
// Commits from the shadow happen only at a period boundary (own or group).
module pwm_cfg_chan
  import pwm_cfg_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld,
  input  logic [CNT_WIDTH-1:0] new_period,
  input  logic [CNT_WIDTH-1:0] new_duty,
  input  logic [CNT_WIDTH-1:0] new_offset,
  input  logic                 new_en,
  input  logic                 grp,
  input  logic                 grp_tick,
  input  logic                 cyc_end,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] duty,
  output logic [CNT_WIDTH-1:0] offset,
  output logic                 run,
  output logic                 pend
);

  chan_state_e state, state_nxt;

  logic [CNT_WIDTH-1:0] shd_period, shd_duty, shd_offset;
  logic                 shd_en, shd_grp;
  logic                 hold, commit, ld_act, ld_shd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CH_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE: begin
        if (ld_act)      state_nxt = new_en ? CH_RUN : CH_IDLE;
        else if (ld_shd) state_nxt = CH_PEND;
      end
      CH_RUN:  if (ld_shd) state_nxt = CH_PEND;
      CH_PEND: if (commit) state_nxt = shd_en ? CH_RUN : CH_IDLE;
      default: state_nxt = CH_IDLE;
    endcase
  end

  // A stopped channel loads directly unless a group write must wait for
  // channel 0's boundary; a running channel always goes through the shadow.
  always_comb begin
    hold   = grp && !grp_tick;
    commit = (state == CH_PEND) && (shd_grp ? grp_tick : cyc_end);
    ld_act = ld && (state == CH_IDLE) && !hold;
    ld_shd = ld && ((state == CH_RUN) || ((state == CH_IDLE) && hold));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_period <= '0;
      shd_duty   <= '0;
      shd_offset <= '0;
      shd_en     <= 1'b0;
      shd_grp    <= 1'b0;
    end else if (ld_shd) begin
      shd_period <= new_period;
      shd_duty   <= new_duty;
      shd_offset <= new_offset;
      shd_en     <= new_en;
      shd_grp    <= grp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      duty   <= '0;
      offset <= '0;
      run    <= 1'b0;
    end else if (ld_act) begin
      period <= new_period;
      duty   <= new_duty;
      offset <= new_offset;
      run    <= new_en;
    end else if (commit) begin
      period <= shd_period;
      duty   <= shd_duty;
      offset <= shd_offset;
      run    <= shd_en;
    end
  end

  assign pend = (state == CH_PEND);

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// PWM configuration scheduler top: write decode, wr_ready mux, err_o register.
// Define PWM_CFG_SYNC_EN to add wr_grp (group commits on channel 0's boundary).
module pwm_cfg_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef PWM_CFG_SYNC_EN
  input  logic                     wr_grp,
`endif
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CHW-1:0]           wr_ch,
  input  logic [CNT_WIDTH-1:0]     wr_period,
  input  logic [CNT_WIDTH-1:0]     wr_duty,
  input  logic [CNT_WIDTH-1:0]     wr_offset,
  input  logic                     wr_en,
  input  logic [NCH-1:0]           cyc_end,
  output logic [NCH*CNT_WIDTH-1:0] period_o,
  output logic [NCH*CNT_WIDTH-1:0] duty_o,
  output logic [NCH*CNT_WIDTH-1:0] offset_o,
  output logic [NCH-1:0]           run_o,
  output logic [NCH-1:0]           pend_o,
  output logic                     err_o
);

  logic           ch_ok, xfer, grp, grp_tick;
  logic [NCH-1:0] ld;
  pwm_cfg_t       wcfg, scfg;
  logic           unused_cfg;

  assign ch_ok    = int'(wr_ch) < NCH;
  // Out-of-range channels stay ready so the host never stalls on them.
  assign wr_ready = !reset && (!ch_ok || !pend_o[wr_ch]);
  assign xfer     = wr_valid && wr_ready;

`ifdef PWM_CFG_SYNC_EN
  assign grp      = wr_grp;
  assign grp_tick = cyc_end[0] || !run_o[0];
`else
  assign grp      = 1'b0;
  assign grp_tick = 1'b0;
`endif

  always_comb begin
    wcfg        = '0;
    wcfg.period = CFG_W'(wr_period);
    wcfg.duty   = CFG_W'(wr_duty);
    wcfg.offset = CFG_W'(wr_offset);
    wcfg.en     = wr_en;
    scfg        = cfg_sanitize(wcfg);
  end

  assign unused_cfg = ^scfg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_o <= 1'b0;
    else       err_o <= xfer && (!ch_ok || cfg_bad(wcfg));
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ld[i] = xfer && ch_ok && (int'(wr_ch) == i);

    pwm_cfg_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .ld         (ld[i]),
      .new_period (scfg.period[CNT_WIDTH-1:0]),
      .new_duty   (scfg.duty[CNT_WIDTH-1:0]),
      .new_offset (scfg.offset[CNT_WIDTH-1:0]),
      .new_en     (scfg.en),
      .grp        (grp),
      .grp_tick   (grp_tick),
      .cyc_end    (cyc_end[i]),
      .period     (period_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .duty       (duty_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .offset     (offset_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .run        (run_o[i]),
      .pend       (pend_o[i])
    );
  end

endmodule
